// File: rtl/activation_control.sv
// activation_control: sequences activation instructions from accumulator reads through the activation unit to unified-buffer writes
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   instr_*_i / instr_ready_o   instruction handshake: accumulator base, buffer base, row count, function, signedness
//   acc_rd_en_o/acc_rd_addr_o   one accumulator read per cycle while issuing
//   act_enable_o/act_function_o/act_signed_o   activation unit controls
//   buf_wr_en_o/buf_wr_addr_o   unified-buffer writes, delayed 1+ACT_LATENCY cycles behind the reads
//   busy_o, done_o              activity flag and one-cycle completion pulse per instruction
//   Function encoding: 0 no_activation, 1 relu, 2 sigmoid, 3 tanh.
// Optional feature: define ACT_CTRL_PERF_EN to add perf_busy_cycles_o, a saturating count of busy cycles.
module activation_control #(
    parameter int ACC_ADDR_WIDTH = 10,
    parameter int BUF_ADDR_WIDTH = 24,
    parameter int LENGTH_WIDTH   = 16,
    parameter int ACT_LATENCY    = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr_i,
    input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr_i,
    input  logic [LENGTH_WIDTH-1:0]   instr_length_i,
    input  logic [1:0]                instr_function_i,
    input  logic                      instr_signed_i,
    output logic                      acc_rd_en_o,
    output logic [ACC_ADDR_WIDTH-1:0] acc_rd_addr_o,
    output logic                      act_enable_o,
    output logic [1:0]                act_function_o,
    output logic                      act_signed_o,
    output logic                      buf_wr_en_o,
    output logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr_o,
    output logic                      busy_o,
`ifdef ACT_CTRL_PERF_EN
    output logic [31:0]               perf_busy_cycles_o,
`endif
    output logic                      done_o
);
    localparam int D = 1 + ACT_LATENCY;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [ACC_ADDR_WIDTH-1:0] acc_q, acc_d, iss_acc;
    logic [BUF_ADDR_WIDTH-1:0] wbuf_q, wbuf_d, iss_buf;
    logic [LENGTH_WIDTH-1:0]   rem_q, rem_d;
    logic [D-1:0]              dv_q, dl_q;
    logic [BUF_ADDR_WIDTH-1:0] da_q [D];
    logic                      issue, iss_last, accept, act_en_d, busy_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wbuf_d   = wbuf_q;
        rem_d    = rem_q;
        issue    = 1'b0;
        iss_last = 1'b0;
        iss_acc  = acc_q;
        iss_buf  = wbuf_q;
        // While draining, only an instruction using the same function can join the pipeline.
        instr_ready_o = (state_q == IDLE) || (state_q == DRAIN && instr_function_i == act_function_o
                        && instr_signed_i == act_signed_o);
        accept = instr_valid_i && instr_ready_o;
        if (state_q == ISSUE) begin
            issue    = 1'b1;
            iss_last = rem_q == LENGTH_WIDTH'(1);
            acc_d    = acc_q + ACC_ADDR_WIDTH'(1);
            wbuf_d   = wbuf_q + BUF_ADDR_WIDTH'(1);
            rem_d    = rem_q - LENGTH_WIDTH'(1);
            state_d  = iss_last ? DRAIN : ISSUE;
        end else if (accept && instr_length_i != '0) begin
            // Row 0 is issued on the accepting edge so chained instructions stream without a bubble.
            issue    = 1'b1;
            iss_acc  = instr_acc_addr_i;
            iss_buf  = instr_buf_addr_i;
            iss_last = instr_length_i == LENGTH_WIDTH'(1);
            acc_d    = instr_acc_addr_i + ACC_ADDR_WIDTH'(1);
            wbuf_d   = instr_buf_addr_i + BUF_ADDR_WIDTH'(1);
            rem_d    = instr_length_i - LENGTH_WIDTH'(1);
            state_d  = iss_last ? DRAIN : ISSUE;
        end else if (state_q == DRAIN && dv_q == '0) begin
            state_d = IDLE;
        end
        act_en_d = issue || (dv_q != '0);
        busy_d   = (state_d != IDLE) || act_en_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            wbuf_q         <= '0;
            rem_q          <= '0;
            dv_q           <= '0;
            dl_q           <= '0;
            for (int k = 0; k < D; k++) da_q[k] <= '0;
            acc_rd_en_o    <= 1'b0;
            acc_rd_addr_o  <= '0;
            act_enable_o   <= 1'b0;
            act_function_o <= 2'd0;
            act_signed_o   <= 1'b0;
            buf_wr_en_o    <= 1'b0;
            buf_wr_addr_o  <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            wbuf_q        <= wbuf_d;
            rem_q         <= rem_d;
            // Delay line: {valid, last, write address} per row, aligned to the activation latency.
            dv_q          <= {dv_q[D-2:0], issue};
            dl_q          <= {dl_q[D-2:0], iss_last};
            da_q[0]       <= iss_buf;
            for (int k = 1; k < D; k++) da_q[k] <= da_q[k-1];
            acc_rd_en_o   <= issue;
            acc_rd_addr_o <= iss_acc;
            if (accept) begin
                act_function_o <= instr_function_i;
                act_signed_o   <= instr_signed_i;
            end
            act_enable_o  <= act_en_d;
            buf_wr_en_o   <= dv_q[D-1];
            buf_wr_addr_o <= da_q[D-1];
            busy_o        <= busy_d;
            done_o        <= (dv_q[D-1] && dl_q[D-1]) || (accept && instr_length_i == '0);
        end
    end

`ifdef ACT_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf_q <= '0;
        else if (busy_o && perf_q != '1) perf_q <= perf_q + 32'd1;
    end

    assign perf_busy_cycles_o = perf_q;
`endif
endmodule

// File: tb/tb_activation_control.sv
// tb_activation_control: randomized and directed checks of activation_control against a cycle-indexed event model
module tb_activation_control;
    localparam int AW = 10, BW = 24, LW = 16, LAT = 3;
    localparam logic [1:0] RELU = 2'd1, SIGMOID = 2'd2, TANH = 2'd3;

    logic          clk = 1'b0, rst_ni = 1'b0;
    logic          instr_valid_i = 1'b0, instr_ready_o, instr_signed_i = 1'b0;
    logic [AW-1:0] instr_acc_addr_i = '0;
    logic [BW-1:0] instr_buf_addr_i = '0;
    logic [LW-1:0] instr_length_i = '0;
    logic [1:0]    instr_function_i = '0, act_function_o;
    logic          acc_rd_en_o, act_enable_o, act_signed_o, buf_wr_en_o, busy_o, done_o;
    logic [AW-1:0] acc_rd_addr_o;
    logic [BW-1:0] buf_wr_addr_o;
`ifdef ACT_CTRL_PERF_EN
    logic [31:0]   perf_busy_cycles_o;
`endif

    activation_control #(.ACC_ADDR_WIDTH(AW), .BUF_ADDR_WIDTH(BW), .LENGTH_WIDTH(LW), .ACT_LATENCY(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_acc_addr_i(instr_acc_addr_i), .instr_buf_addr_i(instr_buf_addr_i),
        .instr_length_i(instr_length_i), .instr_function_i(instr_function_i), .instr_signed_i(instr_signed_i),
        .acc_rd_en_o(acc_rd_en_o), .acc_rd_addr_o(acc_rd_addr_o), .act_enable_o(act_enable_o),
        .act_function_o(act_function_o), .act_signed_o(act_signed_o), .buf_wr_en_o(buf_wr_en_o),
        .buf_wr_addr_o(buf_wr_addr_o), .busy_o(busy_o),
`ifdef ACT_CTRL_PERF_EN
        .perf_busy_cycles_o(perf_busy_cycles_o),
`endif
        .done_o(done_o));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef logic [41:0] vec_t;
    vec_t obs [int];
    always @(negedge clk)
        obs[cyc] = {acc_rd_en_o, acc_rd_en_o ? acc_rd_addr_o : AW'(0), buf_wr_en_o,
                    buf_wr_en_o ? buf_wr_addr_o : BW'(0), done_o, busy_o, act_enable_o,
                    act_enable_o ? act_function_o : 2'd0, act_enable_o & act_signed_o};

    int n_checks = 0, n_pass = 0;

    int m_rd [int], m_wr [int];
    bit m_done [int], m_busy [int];
    logic [2:0] m_fn [int];
    int m_end, rm, ra;
    logic [1:0] last_fn;
    logic last_sg;

    function automatic void model_clear();
        m_rd.delete(); m_wr.delete(); m_done.delete(); m_busy.delete(); m_fn.delete();
        m_end = 0; rm = 0; ra = 0; last_fn = 2'd0; last_sg = 1'b0;
    endfunction

    // Spec timing: reads at E+1+i, writes at E+2+i+LAT, done with the last write (or E+1 for length 0).
    function automatic void model_accept(int e, int acc, int bufa, int len, logic [1:0] fn, logic sg);
        int d;
        for (int i = 0; i < len; i++) begin
            m_rd[e+1+i] = (acc + i) % 1024;
            m_wr[e+2+i+LAT] = (bufa + i) % (1 << 24);
        end
        if (len > 0)
            for (int c = e + 1; c <= e + 1 + len + LAT; c++) begin
                m_busy[c] = 1'b1;
                m_fn[c] = {fn, sg};
            end
        d = (len > 0) ? e + 1 + len + LAT : e + 1;
        m_done[d] = 1'b1;
        if (d > m_end) m_end = d;
        if (len > 0) begin
            rm = e + len;
            ra = e + len + LAT + 2;
        end else begin
            rm = e + 1;
            if (ra < e + 1) ra = e + 1;
        end
        last_fn = fn;
        last_sg = sg;
    endfunction

    function automatic vec_t exp_vec(int c);
        bit r, w, d, b;
        int ra_v, wa_v;
        logic [2:0] f;
        r = m_rd.exists(c) != 0;
        w = m_wr.exists(c) != 0;
        d = m_done.exists(c) != 0;
        b = m_busy.exists(c) != 0;
        ra_v = r ? m_rd[c] : 0;
        wa_v = w ? m_wr[c] : 0;
        f = (m_fn.exists(c) != 0) ? m_fn[c] : 3'd0;
        return {r, AW'(ra_v), w, BW'(wa_v), d, b, b, f};
    endfunction

    task automatic send(input int acc, input int bufa, input int len, input logic [1:0] fn, input logic sg,
                        output int offer, output int e);
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_acc_addr_i = AW'(acc);
        instr_buf_addr_i = BW'(bufa);
        instr_length_i = LW'(len);
        instr_function_i = fn;
        instr_signed_i = sg;
        offer = cyc;
        e = -1;
        for (int k = 0; k < 100 && e < 0; k++) begin
            #1;
            if (instr_ready_o) begin
                e = cyc;
                model_accept(e, acc, bufa, len, fn, sg);
            end else @(negedge clk);
        end
        if (e < 0) begin
            n_checks++;
            $display("FAIL send_timeout: instr_ready_o stayed 0 for 100 cycles, required 1");
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            instr_valid_i = 1'b0;
        end
    endtask

    task automatic settle();
        idle(1);
        while (cyc < m_end + 4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (instr_ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", instr_ready_o);
        else n_pass++;
        n_checks++;
        if ({acc_rd_en_o, acc_rd_addr_o, act_enable_o, act_function_o, act_signed_o, buf_wr_en_o,
             buf_wr_addr_o, busy_o, done_o} !== '0)
            $display("FAIL reset_outputs: rd %b/%h en %b fn %h sg %b wr %b/%h busy %b done %b, required all 0",
                     acc_rd_en_o, acc_rd_addr_o, act_enable_o, act_function_o, act_signed_o,
                     buf_wr_en_o, buf_wr_addr_o, busy_o, done_o);
        else n_pass++;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({busy_o, done_o, acc_rd_en_o, buf_wr_en_o, instr_ready_o} !== 5'b00001)
            $display("FAIL reset_release: busy/done/rd/wr/ready got %b required 00001",
                     {busy_o, done_o, acc_rd_en_o, buf_wr_en_o, instr_ready_o});
        else n_pass++;
`ifdef ACT_CTRL_PERF_EN
        n_checks++;
        if (perf_busy_cycles_o !== 32'd0) $display("FAIL perf_reset: got %0d required 0", perf_busy_cycles_o);
        else n_pass++;
`endif
    endtask

    task automatic test_basic();
        int o, e, t0;
        model_clear();
        t0 = cyc + 1;
        send(5, 100, 4, SIGMOID, 1'b1, o, e);
        settle();
        n_checks++;
        if (e !== o) $display("FAIL basic_accept: accepted cycle %0d required %0d", e, o);
        else n_pass++;
        for (int c = t0; c <= cyc; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c)) $display("FAIL basic cyc %0d: got %h required %h", c, obs[c], exp_vec(c));
            else n_pass++;
        end
`ifdef ACT_CTRL_PERF_EN
        n_checks++;
        if (perf_busy_cycles_o !== 32'd8) $display("FAIL perf_count: got %0d required 8", perf_busy_cycles_o);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        int o1, e1, o2, e2, t0;
        model_clear();
        t0 = cyc + 1;
        send(40, 200, 3, RELU, 1'b0, o1, e1);
        send(43, 203, 3, RELU, 1'b0, o2, e2);
        settle();
        n_checks++;
        if (e2 !== e1 + 3) $display("FAIL b2b_accept: accepted cycle %0d required %0d", e2, e1 + 3);
        else n_pass++;
        for (int c = t0; c <= cyc; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c)) $display("FAIL b2b cyc %0d: got %h required %h", c, obs[c], exp_vec(c));
            else n_pass++;
        end
    endtask

    task automatic test_mismatch();
        int o1, e1, o2, e2, t0;
        model_clear();
        t0 = cyc + 1;
        send(10, 500, 3, RELU, 1'b0, o1, e1);
        send(20, 600, 2, SIGMOID, 1'b0, o2, e2);
        settle();
        n_checks++;
        if (e2 !== e1 + 3 + LAT + 2)
            $display("FAIL mismatch_accept: accepted cycle %0d required %0d", e2, e1 + 3 + LAT + 2);
        else n_pass++;
        for (int c = t0; c <= cyc; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c)) $display("FAIL mismatch cyc %0d: got %h required %h", c, obs[c], exp_vec(c));
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        int o, e, t0;
        model_clear();
        t0 = cyc + 1;
        send(7, 9, 0, TANH, 1'b0, o, e);
        settle();
        for (int c = t0; c <= cyc; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c)) $display("FAIL zero_len cyc %0d: got %h required %h", c, obs[c], exp_vec(c));
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int o, e, t0;
        model_clear();
        t0 = cyc + 1;
        send(1022, (1 << 24) - 1, 4, RELU, 1'b1, o, e);
        settle();
        for (int c = t0; c <= cyc; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c)) $display("FAIL wrap cyc %0d: got %h required %h", c, obs[c], exp_vec(c));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int o, e, t0;
        model_clear();
        send(3, 50, 10, RELU, 1'b0, o, e);
        idle(4);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({instr_ready_o, acc_rd_en_o, act_enable_o, buf_wr_en_o, busy_o, done_o, act_function_o} !== 8'b10000000)
            $display("FAIL reset_mid_outputs: ready/rd/en/wr/busy/done/fn got %b required 10000000",
                     {instr_ready_o, acc_rd_en_o, act_enable_o, buf_wr_en_o, busy_o, done_o, act_function_o});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        model_clear();
        t0 = cyc + 1;
        idle(20);
        #1;
        for (int c = t0; c <= cyc; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c)) $display("FAIL reset_mid cyc %0d: got %h required %h", c, obs[c], exp_vec(c));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int o, e, t0, p_rm, p_ra, pred, len;
        bit p_match;
        logic [1:0] fn;
        logic sg;
        model_clear();
        t0 = cyc + 1;
        for (int n = 0; n < 16; n++) begin
            int gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
            len = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) begin
                fn = last_fn;
                sg = last_sg;
            end else begin
                fn = 2'($urandom_range(0, 3));
                sg = 1'($urandom_range(0, 1));
            end
            p_rm = rm;
            p_ra = ra;
            p_match = (fn == last_fn) && (sg == last_sg);
            send($urandom_range(0, 1023), $urandom_range(0, (1 << 24) - 1), len, fn, sg, o, e);
            pred = p_match ? p_rm : p_ra;
            if (pred < o) pred = o;
            n_checks++;
            if (e !== pred) $display("FAIL random_accept #%0d: accepted cycle %0d required %0d", n, e, pred);
            else n_pass++;
        end
        settle();
        for (int c = t0; c <= cyc; c++) begin
            n_checks++;
            if (obs[c] !== exp_vec(c)) $display("FAIL random cyc %0d: got %h required %h", c, obs[c], exp_vec(c));
            else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_mismatch();
        test_zero_len();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/activation_control.md
# activation_control

Sequencer for the activation unit. Accepts activation instructions (accumulator source, unified-buffer destination, row count, function, signedness) and streams rows through the activation datapath. It issues one accumulator read per cycle, drives the activation unit's enable, function and signedness inputs, and emits matching unified-buffer write strobes and addresses aligned to the activation pipeline latency. It sits between the TPU instruction dispatcher and the accumulator → activation → unified-buffer path.

## Interface
Parameters:
- ACC_ADDR_WIDTH, 10, accumulator row address width
- BUF_ADDR_WIDTH, 24, unified-buffer row address width
- LENGTH_WIDTH, 16, row-count width
- ACT_LATENCY, 3, activation unit data_in→data_out latency in cycles (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when valid && ready
- instr_acc_addr  in  ACC_ADDR_WIDTH  first accumulator row
- instr_buf_addr  in  BUF_ADDR_WIDTH  first unified-buffer row
- instr_length  in  LENGTH_WIDTH  row count
- instr_function  in  activation_type  activation function
- instr_signed  in  1  signed interpretation
- acc_rd_en  out  1  accumulator read strobe; data valid on the next cycle
- acc_rd_addr  out  ACC_ADDR_WIDTH  accumulator read address
- act_enable  out  1  activation unit enable
- act_function  out  activation_type  to activation_function
- act_signed  out  1  to is_signed
- buf_wr_en  out  1  unified-buffer write strobe
- buf_wr_addr  out  BUF_ADDR_WIDTH  unified-buffer write address
- busy  out  1  instruction or in-flight row present
- done  out  1  one-cycle pulse per completed instruction

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: instr_ready=1. Acceptance latches the function and signedness into act_function/act_signed. Nonzero length → ISSUE. Zero length → done pulse next cycle, remain IDLE, no reads.
- ISSUE: one row per cycle; acc_rd_addr = base+i, i = 0..length-1. instr_ready=0. After the last row: → DRAIN.
- DRAIN: in-flight rows complete. instr_ready = (instr_function==act_function && instr_signed==act_signed). A matching instruction → ISSUE without a bubble. A mismatched instruction waits until the pipeline is empty; the FSM then returns to IDLE and accepts it.
- act_function/act_signed change only when the pipeline is empty, so in-flight rows are never corrupted.
- Delay line of depth D = 1+ACT_LATENCY carries {valid, buf address, last flag}. Its output drives buf_wr_en/buf_wr_addr. done = valid && last at the delay-line output.
- act_enable = 1 while any row is in the delay line or being issued.
- Address arithmetic is modulo 2^width; wrap-around is silent.
- busy = (state≠IDLE) || delay line nonempty.

## Timing
- Reset values: instr_ready=1, acc_rd_en=0, acc_rd_addr=0, act_enable=0, act_function=no_activation, act_signed=0, buf_wr_en=0, buf_wr_addr=0, busy=0, done=0. Every output is registered except instr_ready.
- Acceptance at edge E: row i read strobe in cycle E+1+i. Write of row i in cycle E+2+i+ACT_LATENCY. done coincides with the last write.
- Back-to-back matching instructions: continuous acc_rd_en with no gap. Writes are contiguous.
- Reset asserted mid-operation: state, counters and delay line clear immediately. In-flight writes are dropped, and no done is emitted.

## Configuration
- ACT_CTRL_PERF_EN defined:
  - adds output perf_busy_cycles (32 bits)
  - counts cycles with busy=1, saturates at 2^32-1, cleared only by reset
- Undefined: the port and counter are absent.

## Test plan
- Reset, then instruction acc=5, buf=100, len=4, sigmoid, signed → reads at 5..8 in cycles E+1..E+4. Writes at 100..103 in cycles E+5..E+8 (ACT_LATENCY=3). done in cycle E+8.
- Two relu/unsigned instructions back-to-back, len=3 each → six consecutive reads with no gap; two done pulses 3 cycles apart.
- relu instruction followed immediately by sigmoid → instr_ready low until the last relu write. act_function changes only after the pipeline is empty.
- len=0 → done exactly one cycle after acceptance. No acc_rd_en or buf_wr_en. busy stays 0.
- acc=1022, buf=2^24-1, len=4 → read addresses 1022,1023,0,1 and write addresses 2^24-1,0,1,2.
- Reset asserted in the middle of a len=10 instruction → all outputs return to reset values, and no further writes or done pulses appear. With ACT_CTRL_PERF_EN defined, perf_busy_cycles reads 0 after reset and 8 after one len=4 instruction.
